// File: rtl/store_trace_checker.sv
// In-order store-trace checker for the data-memory write port.
// Compares core stores against a preloaded trace and gathers CPI counters.
module store_trace_checker #(
    parameter int unsigned TRACE_DEPTH = 256,
    parameter int unsigned AW          = 8,
    parameter int unsigned TIMEOUT     = 25000
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic [31:0]   pc_finished,
    input  logic [AW:0]   trace_len,
    input  logic          load_we,
    input  logic [AW-1:0] load_idx,
    input  logic [31:0]   load_addr,
    input  logic [31:0]   load_data,
    input  logic [31:0]   pc,
    input  logic          memwrite,
    input  logic [31:0]   dataadr,
    input  logic [31:0]   writedata,
    input  logic          stallD,
    input  logic          flushD,
    output logic          cpu_hold,
    output logic          busy,
    output logic          done,
    output logic          pass,
    output logic          timeout,
    output logic [15:0]   error_count,
    output logic [AW:0]   first_err_idx,
    output logic [31:0]   cycle_count,
    output logic [31:0]   instr_count
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    localparam logic [AW:0] NO_ERR = '1;

    state_t      r_state;
    logic [63:0] r_trace [TRACE_DEPTH];
    logic [AW:0] r_idx;
    logic [15:0] r_err_cnt;
    logic [AW:0] r_first_err;
    logic [31:0] r_cycle_cnt;
    logic [31:0] r_instr_cnt;
    logic        r_pass;
    logic        r_timeout;

    state_t      w_state_next;
    logic [AW:0] w_idx_next;
    logic [15:0] w_err_cnt_next;
    logic [AW:0] w_first_err_next;
    logic [31:0] w_cycle_cnt_next;
    logic [31:0] w_instr_cnt_next;
    logic        w_pass_next;
    logic        w_timeout_next;
    logic        w_finish;
    logic        w_err;
    logic [63:0] w_entry;

    assign w_finish = (pc == pc_finished);
    assign w_entry  = r_trace[r_idx[AW-1:0]];

    // Reset term lets the core freeze in the very cycle reset is sampled.
    assign cpu_hold = reset | ~((r_state == S_RUN) & ~w_finish);
    assign busy          = (r_state == S_RUN);
    assign done          = (r_state == S_DONE);
    assign pass          = r_pass;
    assign timeout       = r_timeout;
    assign error_count   = r_err_cnt;
    assign first_err_idx = r_first_err;
    assign cycle_count   = r_cycle_cnt;
    assign instr_count   = r_instr_cnt;

    // Trace RAM is writable only while idle; contents survive reset.
    always_ff @(posedge clk) begin
        if (r_state == S_IDLE && load_we) begin
            r_trace[load_idx] <= {load_addr, load_data};
        end
    end

    always_comb begin
        w_state_next     = r_state;
        w_idx_next       = r_idx;
        w_err_cnt_next   = r_err_cnt;
        w_first_err_next = r_first_err;
        w_cycle_cnt_next = r_cycle_cnt;
        w_instr_cnt_next = r_instr_cnt;
        w_pass_next      = r_pass;
        w_timeout_next   = r_timeout;
        w_err            = 1'b0;

        case (r_state)
            S_IDLE, S_DONE: begin
                if (start) begin
                    w_state_next     = S_RUN;
                    w_idx_next       = '0;
                    w_err_cnt_next   = '0;
                    w_first_err_next = NO_ERR;
                    w_cycle_cnt_next = '0;
                    w_instr_cnt_next = '0;
                    w_pass_next      = 1'b0;
                    w_timeout_next   = 1'b0;
                end
            end
            S_RUN: begin
                if (w_finish) begin
                    w_state_next = S_DONE;
                    w_err        = (r_idx < trace_len);
                end else begin
                    w_cycle_cnt_next = r_cycle_cnt + 32'd1;
                    if (~flushD & ~stallD) begin
                        w_instr_cnt_next = r_instr_cnt + 32'd1;
                    end
                    if (memwrite) begin
                        if (r_idx >= trace_len) begin
                            w_err = 1'b1;
                        end else begin
                            w_err      = ({dataadr, writedata} != w_entry);
                            w_idx_next = r_idx + (AW+1)'(1);
                        end
                    end
                    if (r_cycle_cnt == 32'(TIMEOUT - 1)) begin
                        w_state_next   = S_DONE;
                        w_timeout_next = 1'b1;
                        w_pass_next    = 1'b0;
                    end
                end
            end
            default: w_state_next = S_IDLE;
        endcase

        if (w_err) begin
            if (r_err_cnt != 16'hFFFF) begin
                w_err_cnt_next = r_err_cnt + 16'd1;
            end
            if (r_first_err == NO_ERR) begin
                w_first_err_next = r_idx;
            end
        end

        if (r_state == S_RUN && w_finish) begin
            w_pass_next = (w_err_cnt_next == 16'd0);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_idx       <= '0;
            r_err_cnt   <= '0;
            r_first_err <= NO_ERR;
            r_cycle_cnt <= '0;
            r_instr_cnt <= '0;
            r_pass      <= 1'b0;
            r_timeout   <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_idx       <= w_idx_next;
            r_err_cnt   <= w_err_cnt_next;
            r_first_err <= w_first_err_next;
            r_cycle_cnt <= w_cycle_cnt_next;
            r_instr_cnt <= w_instr_cnt_next;
            r_pass      <= w_pass_next;
            r_timeout   <= w_timeout_next;
        end
    end

endmodule

// File: tb/tb_store_trace_checker.sv
// Directed self-checking bench for store_trace_checker.
module tb_store_trace_checker;

    logic        clk = 1'b0;
    logic        reset, start, load_we, memwrite, stallD, flushD;
    logic [31:0] pc_finished, load_addr, load_data, pc, dataadr, writedata;
    logic [8:0]  trace_len;
    logic [7:0]  load_idx;
    logic        cpu_hold, busy, done, pass, timeout;
    logic [15:0] error_count;
    logic [8:0]  first_err_idx;
    logic [31:0] cycle_count, instr_count;

    int n_tests = 0;
    int n_fail  = 0;
    int n_ticks;

    store_trace_checker dut (
        .clk(clk), .reset(reset), .start(start), .pc_finished(pc_finished),
        .trace_len(trace_len), .load_we(load_we), .load_idx(load_idx),
        .load_addr(load_addr), .load_data(load_data), .pc(pc),
        .memwrite(memwrite), .dataadr(dataadr), .writedata(writedata),
        .stallD(stallD), .flushD(flushD), .cpu_hold(cpu_hold), .busy(busy),
        .done(done), .pass(pass), .timeout(timeout), .error_count(error_count),
        .first_err_idx(first_err_idx), .cycle_count(cycle_count),
        .instr_count(instr_count)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic load(input logic [7:0] idx, input logic [31:0] a, input logic [31:0] d);
        load_we = 1'b1; load_idx = idx; load_addr = a; load_data = d;
        tick();
        load_we = 1'b0;
    endtask

    task automatic do_start();
        start = 1'b1; pc = 32'h0;
        tick();
        start = 1'b0;
    endtask

    task automatic store(input logic [31:0] a, input logic [31:0] d);
        pc = 32'h10; memwrite = 1'b1; dataadr = a; writedata = d;
        tick();
        memwrite = 1'b0;
    endtask

    task automatic finish();
        pc = 32'h3C;
        tick();
        pc = 32'h0;
    endtask

    task automatic chk_result(input string tag, input logic [31:0] p, input logic [31:0] e,
                              input logic [31:0] f);
        chk({tag, ".done"}, 32'(done), 32'd1);
        chk({tag, ".pass"}, 32'(pass), p);
        chk({tag, ".errs"}, 32'(error_count), e);
        chk({tag, ".first"}, 32'(first_err_idx), f);
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; load_we = 1'b0; memwrite = 1'b0;
        stallD = 1'b0; flushD = 1'b0; pc_finished = 32'h3C; trace_len = 9'd3;
        load_idx = '0; load_addr = '0; load_data = '0; pc = '0;
        dataadr = '0; writedata = '0;
        tick(); tick();
        reset = 1'b0;
        chk("rst.done", 32'(done), 32'd0);
        chk("rst.busy", 32'(busy), 32'd0);
        chk("rst.hold", 32'(cpu_hold), 32'd1);
        chk("rst.pass", 32'(pass), 32'd0);
        chk("rst.first", 32'(first_err_idx), 32'h1FF);
        chk("rst.cycles", cycle_count, 32'd0);

        load(8'd0, 32'h54, 32'h7);
        load(8'd1, 32'h58, 32'hA);
        load(8'd2, 32'h5C, 32'h1);

        // Matching trace
        do_start();
        chk("t1.busy", 32'(busy), 32'd1);
        chk("t1.hold", 32'(cpu_hold), 32'd0);
        store(32'h54, 32'h7); store(32'h58, 32'hA); store(32'h5C, 32'h1);
        pc = 32'h3C; #1;
        chk("t1.hold_fin", 32'(cpu_hold), 32'd1);
        finish();
        chk_result("t1", 32'd1, 32'd0, 32'h1FF);
        chk("t1.cycles", cycle_count, 32'd3);
        chk("t1.instrs", instr_count, 32'd3);
        chk("t1.hold_done", 32'(cpu_hold), 32'd1);

        // Data mismatch on second store
        do_start();
        chk("t2.fresh", 32'(error_count), 32'd0);
        store(32'h54, 32'h7); store(32'h58, 32'hB); store(32'h5C, 32'h1);
        finish();
        chk_result("t2", 32'd0, 32'd1, 32'd1);

        // Missing third store
        do_start();
        store(32'h54, 32'h7); store(32'h58, 32'hA);
        finish();
        chk_result("t3", 32'd0, 32'd1, 32'd2);

        // Extra fourth store
        do_start();
        store(32'h54, 32'h7); store(32'h58, 32'hA); store(32'h5C, 32'h1);
        store(32'h60, 32'h5);
        finish();
        chk_result("t4", 32'd0, 32'd1, 32'd3);

        // Counters: 10 cycles, 2 stalled, 1 flushed; store in finish cycle ignored
        do_start();
        pc = 32'h10;
        for (int i = 0; i < 10; i++) begin
            stallD = (i < 2);
            flushD = (i == 2);
            tick();
        end
        stallD = 1'b0; flushD = 1'b0;
        memwrite = 1'b1; dataadr = 32'h54; writedata = 32'h7;
        finish();
        memwrite = 1'b0;
        chk("t5.cycles", cycle_count, 32'd10);
        chk("t5.instrs", instr_count, 32'd7);
        chk_result("t5", 32'd0, 32'd1, 32'd0);

        // Timeout
        do_start();
        pc = 32'h10;
        n_ticks = 0;
        for (int i = 0; i < 30000; i++) begin
            tick();
            n_ticks++;
            if (done) break;
        end
        chk("t6.ticks", 32'(n_ticks), 32'd25000);
        chk("t6.done", 32'(done), 32'd1);
        chk("t6.timeout", 32'(timeout), 32'd1);
        chk("t6.pass", 32'(pass), 32'd0);
        chk("t6.hold", 32'(cpu_hold), 32'd1);
        chk("t6.cycles", cycle_count, 32'd25000);

        // Finish on the cycle that would otherwise time out
        do_start();
        pc = 32'h10;
        repeat (24999) tick();
        chk("t7.busy", 32'(busy), 32'd1);
        finish();
        chk("t7.done", 32'(done), 32'd1);
        chk("t7.timeout", 32'(timeout), 32'd0);
        chk("t7.cycles", cycle_count, 32'd24999);

        // Reset mid-run
        do_start();
        store(32'h54, 32'h7); store(32'h58, 32'hA);
        pc = 32'h10; reset = 1'b1; #1;
        chk("t8.hold_rst", 32'(cpu_hold), 32'd1);
        tick();
        reset = 1'b0;
        chk("t8.busy", 32'(busy), 32'd0);
        chk("t8.done", 32'(done), 32'd0);
        chk("t8.cycles", cycle_count, 32'd0);
        chk("t8.first", 32'(first_err_idx), 32'h1FF);

        // load_we during RUN must not touch the trace
        do_start();
        pc = 32'h10;
        load_we = 1'b1; load_idx = 8'd0; load_addr = 32'hDEAD; load_data = 32'hBEEF;
        tick();
        load_we = 1'b0;
        store(32'h54, 32'h7); store(32'h58, 32'hA); store(32'h5C, 32'h1);
        finish();
        chk_result("t9", 32'd1, 32'd0, 32'h1FF);
        chk("t9.cycles", cycle_count, 32'd4);

        // Back-to-back run from DONE gets fresh counts
        do_start();
        store(32'h54, 32'h7); store(32'h58, 32'hA); store(32'h5C, 32'h1);
        finish();
        chk_result("t10", 32'd1, 32'd0, 32'h1FF);
        chk("t10.cycles", cycle_count, 32'd3);

        // Empty trace: no stores passes, any store fails
        trace_len = 9'd0;
        do_start();
        finish();
        chk_result("t11", 32'd1, 32'd0, 32'h1FF);
        do_start();
        store(32'h54, 32'h7);
        finish();
        chk_result("t12", 32'd0, 32'd1, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/store_trace_checker.md
Name: store_trace_checker

Overview:
- Synthesizable run-time monitor on the CPU's data-memory write port, alongside dmem.
- Consumes every store the pipelined mips core issues and compares it in order against a preloaded expected trace of address/data pairs.
- Detects program end by PC match and counts cycles and retired instructions for CPI.
- Gates the core with a hold output and reports pass/fail, error count and timeout.

Parameters:
- TRACE_DEPTH, 256, number of expected-store entries; power of two.
- AW, 8, trace index width; equals log2(TRACE_DEPTH).
- TIMEOUT, 25000, RUN-state cycle limit before forced termination.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  begin a run; honoured in IDLE or DONE.
- pc_finished  in  32  PC value that marks program end.
- trace_len  in  AW+1  number of valid expected entries, 0..TRACE_DEPTH.
- load_we  in  1  trace write strobe; honoured in IDLE only.
- load_idx  in  AW  trace entry index.
- load_addr  in  32  expected store address.
- load_data  in  32  expected store data.
- pc  in  32  core fetch PC.
- memwrite  in  1  core store strobe, ungated.
- dataadr  in  32  core store address (aluout).
- writedata  in  32  core store data.
- stallD  in  1  decode stall from hazard unit.
- flushD  in  1  decode flush.
- cpu_hold  out  1  freeze core clock-enable and store enable.
- busy  out  1  state==RUN.
- done  out  1  state==DONE.
- pass  out  1  valid when done.
- timeout  out  1  run ended by TIMEOUT.
- error_count  out  16  saturating mismatch count.
- first_err_idx  out  AW+1  trace index of first error; all-ones if none.
- cycle_count  out  32  RUN cycles.
- instr_count  out  32  retired-instruction proxy.

Behaviour:
- Reset: state=IDLE; all counters 0; pass=0; timeout=0; first_err_idx=all-ones; trace index idx=0. Trace RAM contents are not cleared.
- cpu_hold is combinational: 1 unless state==RUN and pc!=pc_finished.
- IDLE:
  - load_we writes {load_addr, load_data} into entry load_idx.
  - start -> RUN, clearing counters, idx, pass, timeout and first_err_idx.
- DONE:
  - load_we is ignored.
  - start behaves as in IDLE, so back-to-back runs need no reset.
- start while in RUN is ignored.
- RUN, each cycle:
  - finish = (pc==pc_finished).
  - If finish: go to DONE.
    - If idx<trace_len (missing stores), error_count += 1 and first_err_idx takes idx if still all-ones.
    - pass = (error_count_next==0).
    - A memwrite in the finish cycle is ignored: not checked, idx unchanged.
  - Else:
    - cycle_count += 1.
    - If ~flushD & ~stallD: instr_count += 1.
    - If memwrite:
      - If idx>=trace_len, the store is an extra store: error.
      - Else if {dataadr, writedata} != trace[idx]: mismatch error.
      - idx increments (saturates at trace_len) regardless of the result.
  - An error increments error_count (saturates at 16'hFFFF) and sets first_err_idx=idx if still all-ones.
  - If cycle_count reaches TIMEOUT-1 without finish: next state DONE, timeout=1, pass=0. Missing-store check is skipped.
- Trace read is combinational (or same-cycle): the comparison uses the entry at the current idx with zero added latency.
- Finish and timeout in the same cycle: finish wins and timeout stays 0.
- trace_len=0: any store is an error; pass requires zero stores.
- Reset mid-RUN returns to IDLE immediately; cpu_hold is asserted the same cycle reset is sampled.
- Outputs in DONE hold until the next start or reset.

Test Plan:
- Load 3 entries ([0x54]=7, [0x58]=0xA, [0x5C]=0x1), start, drive those stores, then pc=pc_finished=0x3C -> done=1, pass=1, error_count=0, first_err_idx=0x1FF.
- Same trace, but second store writedata=0xB -> pass=0, error_count=1, first_err_idx=1. The third store still matches.
- Only 2 of 3 stores before finish -> error_count=1, first_err_idx=2. One extra 4th store instead -> error_count=1, first_err_idx=3.
- 10 RUN cycles with stallD high for 2 and flushD high for 1 -> cycle_count=10, instr_count=7. memwrite asserted in the finish cycle is not counted.
- pc never matches, TIMEOUT=25000 -> done after 25000 RUN cycles, timeout=1, pass=0, cpu_hold=1.
- Reset asserted mid-RUN -> IDLE next edge, counters 0. load_we during RUN does not alter the trace (verify by rerunning the original trace -> pass). Two consecutive starts from DONE each give fresh counts.
